// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline hazard/forwarding unit.
//   fwd_sel_t     - operand mux select (register file / writeback / memory-stage ALU)
//   stage_ctrl_t  - per-stage shadow of the hazard-relevant instruction fields
//   BUBBLE        - shadow value of an empty pipeline slot
//   fwd_select()  - forwarding decision for one Execute-stage source register
package hazard_pkg;

    localparam int REG_W = 5;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic [1:0]       result_src;
        logic             mem_write;
    } stage_ctrl_t;

    localparam stage_ctrl_t BUBBLE = '0;

    // Memory stage wins over writeback because it holds the younger value.
    // x0 is hard-wired zero and must never be forwarded.
    function automatic fwd_sel_t fwd_select(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rd_m,
        input logic             reg_write_m,
        input logic [REG_W-1:0] rd_w,
        input logic             reg_write_w
    );
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            return FWD_MEM;
        end
        if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one pipeline-stage shadow register of hazard control fields.
//   clk, rst - clock, asynchronous active-high reset (loads BUBBLE)
//   en       - advance enable; register holds when low
//   clr      - synchronous clear to BUBBLE, effective only when en is high
//   d, q     - next / current stage contents
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  stage_ctrl_t d,
    output stage_ctrl_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= clr ? BUBBLE : d;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: Execute-stage operand forwarding, load-use stall,
// branch flush and data-memory wait freeze for a 5-stage pipeline.
//   clk, rst                      - clock, asynchronous active-high reset
//   rs1_d, rs2_d, rd_d            - Decode-stage register indices
//   reg_write_d, result_src_d,
//   mem_write_d                   - Decode-stage control fields
//   pc_src_e                      - taken branch/jump resolved in Execute
//   mem_ready                     - data memory completes the Memory-stage access
//   forward_a_e, forward_b_e      - operand mux selects (00 RF, 01 WB, 10 MEM)
//   stall_f, stall_d              - hold PC / IF-ID
//   flush_d, flush_e              - clear IF-ID / ID-EX
//   freeze                        - hold every pipeline register during a memory wait
//   mem_timeout                   - sticky: memory wait reached MAX_WAIT cycles
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_W,
    parameter int MAX_WAIT       = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rd_d,
    input  logic                      reg_write_d,
    input  logic [1:0]                result_src_d,
    input  logic                      mem_write_d,
    input  logic                      pc_src_e,
    input  logic                      mem_ready,
    output logic [1:0]                forward_a_e,
    output logic [1:0]                forward_b_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic                      freeze,
    output logic                      mem_timeout
);

    localparam int WAIT_CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE = WAIT_CNT_W'(1);
    localparam logic [WAIT_CNT_W-1:0] CNT_MAX = WAIT_CNT_W'(MAX_WAIT);

    typedef enum logic {
        W_IDLE,
        W_WAIT
    } wait_state_t;

    stage_ctrl_t d_ctrl;
    stage_ctrl_t stage_in [3];
    stage_ctrl_t stage_q  [3];
    stage_ctrl_t e_q, m_q, w_q;

    logic lw_stall;
    logic mem_access_m;
    logic freeze_raw;
    logic advance;
    logic flush_e_int;
    logic unused_w_bits;

    wait_state_t               state_reg;
    logic [WAIT_CNT_W-1:0]     cnt_reg;
    logic                      timeout_reg;

    assign d_ctrl = '{rs1: rs1_d, rs2: rs2_d, rd: rd_d, reg_write: reg_write_d,
                      result_src: result_src_d, mem_write: mem_write_d};

    // Index 0 = Execute, 1 = Memory, 2 = Writeback. Only the Execute slot
    // takes a flush; later slots simply inherit whatever entered Execute.
    assign stage_in[0] = d_ctrl;
    assign stage_in[1] = stage_q[0];
    assign stage_in[2] = stage_q[1];

    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
        hazard_stage_reg u_stage (
            .clk (clk),
            .rst (rst),
            .en  (advance),
            .clr ((gi == 0) ? flush_e_int : 1'b0),
            .d   (stage_in[gi]),
            .q   (stage_q[gi])
        );
    end

    assign e_q = stage_q[0];
    assign m_q = stage_q[1];
    assign w_q = stage_q[2];

    // Writeback slot only needs rd/reg_write for forwarding.
    assign unused_w_bits = ^{w_q.rs1, w_q.rs2, w_q.result_src, w_q.mem_write};

    assign forward_a_e = fwd_select(e_q.rs1, m_q.rd, m_q.reg_write, w_q.rd, w_q.reg_write);
    assign forward_b_e = fwd_select(e_q.rs2, m_q.rd, m_q.reg_write, w_q.rd, w_q.reg_write);

    assign lw_stall = (e_q.result_src == RESULT_LOAD) && e_q.reg_write && (e_q.rd != '0)
                      && ((e_q.rd == rs1_d) || (e_q.rd == rs2_d));

    // mem_ready is only meaningful while Memory holds a load or store.
    assign mem_access_m = (m_q.result_src == RESULT_LOAD) || m_q.mem_write;
    assign freeze_raw   = mem_access_m && !mem_ready;
    assign advance      = !freeze_raw;

    // A branch outranks load-use: the dependent instruction is squashed anyway.
    // While frozen nothing moves, so a pending branch is seen again afterwards.
    assign flush_e_int = (lw_stall || pc_src_e) && !freeze_raw;

    // Shadows are bubbles in reset, so only pc_src_e paths need explicit gating.
    assign stall_f     = lw_stall && !pc_src_e && !freeze_raw;
    assign stall_d     = lw_stall && !pc_src_e && !freeze_raw;
    assign flush_d     = pc_src_e && !freeze_raw && !rst;
    assign flush_e     = flush_e_int && !rst;
    assign freeze      = freeze_raw;
    assign mem_timeout = timeout_reg;

    // cnt_reg equals the number of completed frozen cycles; timeout is flagged
    // on the edge where that count reaches MAX_WAIT with the access still pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= W_IDLE;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                W_IDLE: begin
                    if (freeze_raw) begin
                        state_reg <= W_WAIT;
                        cnt_reg   <= CNT_ONE;
                        if (CNT_ONE == CNT_MAX) begin
                            timeout_reg <= 1'b1;
                        end
                    end
                end
                W_WAIT: begin
                    if (!freeze_raw) begin
                        state_reg <= W_IDLE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                        if ((cnt_reg + CNT_ONE) == CNT_MAX) begin
                            timeout_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= W_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed scenarios plus randomized traffic checked
// against a behavioural pipeline model kept in the bench.
module tb_hazard_forward_unit;

    localparam int MAX_WAIT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       reg_write_d;
    logic [1:0] result_src_d;
    logic       mem_write_d;
    logic       pc_src_e;
    logic       mem_ready;
    logic [1:0] forward_a_e, forward_b_e;
    logic       stall_f, stall_d, flush_d, flush_e, freeze, mem_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_ADDR_WIDTH(5), .MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rd_d         (rd_d),
        .reg_write_d  (reg_write_d),
        .result_src_d (result_src_d),
        .mem_write_d  (mem_write_d),
        .pc_src_e     (pc_src_e),
        .mem_ready    (mem_ready),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .freeze       (freeze),
        .mem_timeout  (mem_timeout)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic [1:0] rsrc;
        logic       mw;
    } ins_t;

    localparam ins_t NOP = '0;

    ins_t mdl [0:2];          // 0 = instruction in E, 1 = in M, 2 = in W
    int   frz_edges;          // consecutive clock edges spent frozen
    logic mdl_timeout;

    logic [1:0] exp_fa, exp_fb;
    logic       exp_lw, exp_freeze, exp_stall, exp_flush_d, exp_flush_e;

    function automatic logic [1:0] src_for(input logic [4:0] rs, input ins_t m, input ins_t w);
        if (rs != 5'd0 && m.rw && m.rd == rs) return 2'b10;
        if (rs != 5'd0 && w.rw && w.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        exp_fa      = src_for(mdl[0].rs1, mdl[1], mdl[2]);
        exp_fb      = src_for(mdl[0].rs2, mdl[1], mdl[2]);
        exp_lw      = (mdl[0].rsrc == 2'b01) && mdl[0].rw && (mdl[0].rd != 5'd0)
                      && ((mdl[0].rd == rs1_d) || (mdl[0].rd == rs2_d));
        exp_freeze  = ((mdl[1].rsrc == 2'b01) || mdl[1].mw) && !mem_ready && !rst;
        exp_stall   = !rst && exp_lw && !pc_src_e && !exp_freeze;
        exp_flush_d = !rst && pc_src_e && !exp_freeze;
        exp_flush_e = !rst && (exp_lw || pc_src_e) && !exp_freeze;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) mdl[i] <= NOP;
            frz_edges   <= 0;
            mdl_timeout <= 1'b0;
        end else if (exp_freeze) begin
            frz_edges <= frz_edges + 1;
            if (frz_edges + 1 >= MAX_WAIT) mdl_timeout <= 1'b1;
        end else begin
            mdl[2]    <= mdl[1];
            mdl[1]    <= mdl[0];
            mdl[0]    <= exp_flush_e ? NOP
                         : {rs1_d, rs2_d, rd_d, reg_write_d, result_src_d, mem_write_d};
            frz_edges <= 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         input logic rw, input logic [1:0] rsrc, input logic mw,
                         input logic pcs, input logic rdy);
        @(negedge clk);
        rs1_d = s1; rs2_d = s2; rd_d = d;
        reg_write_d = rw; result_src_d = rsrc; mem_write_d = mw;
        pc_src_e = pcs; mem_ready = rdy;
        #1;
    endtask

    task automatic flush_pipe();
        repeat (3) drive(0, 0, 0, 0, 2'b00, 0, 0, 1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        #1;
        checks += 8;
        if (forward_a_e !== 2'b00) begin errors++; $display("FAIL rst_fa: got %b want 00", forward_a_e); end
        if (forward_b_e !== 2'b00) begin errors++; $display("FAIL rst_fb: got %b want 00", forward_b_e); end
        if (stall_f !== 1'b0) begin errors++; $display("FAIL rst_stall_f: got %b want 0", stall_f); end
        if (stall_d !== 1'b0) begin errors++; $display("FAIL rst_stall_d: got %b want 0", stall_d); end
        if (flush_d !== 1'b0) begin errors++; $display("FAIL rst_flush_d: got %b want 0", flush_d); end
        if (flush_e !== 1'b0) begin errors++; $display("FAIL rst_flush_e: got %b want 0", flush_e); end
        if (freeze !== 1'b0) begin errors++; $display("FAIL rst_freeze: got %b want 0", freeze); end
        if (mem_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", mem_timeout); end
        @(negedge clk);
        rst = 1'b0; pc_src_e = 1'b0; mem_ready = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_forwarding();
        flush_pipe();
        drive(1, 2, 5, 1, 2'b00, 0, 0, 1);          // add x5
        drive(5, 0, 6, 1, 2'b00, 0, 0, 1);          // reads x5
        drive(5, 0, 7, 1, 2'b00, 0, 0, 1);          // reads x5 again
        checks += 3;
        if (forward_a_e !== 2'b10) begin errors++; $display("FAIL fwd_mem_a: got %b want 10", forward_a_e); end
        if (forward_b_e !== 2'b00) begin errors++; $display("FAIL fwd_mem_b: got %b want 00", forward_b_e); end
        if (stall_f !== 1'b0) begin errors++; $display("FAIL fwd_no_stall: got %b want 0", stall_f); end
        drive(0, 0, 0, 0, 2'b00, 0, 0, 1);
        checks++;
        if (forward_a_e !== 2'b01) begin errors++; $display("FAIL fwd_wb_a: got %b want 01", forward_a_e); end
        $display("test_forwarding done");
    endtask

    task automatic test_priority_x0();
        flush_pipe();
        drive(0, 0, 7, 1, 2'b00, 0, 0, 1);
        drive(0, 0, 7, 1, 2'b00, 0, 0, 1);
        drive(0, 7, 1, 1, 2'b00, 0, 0, 1);
        drive(0, 0, 0, 0, 2'b00, 0, 0, 1);
        checks += 2;
        if (forward_b_e !== 2'b10) begin errors++; $display("FAIL prio_b: got %b want 10", forward_b_e); end
        if (forward_a_e !== 2'b00) begin errors++; $display("FAIL prio_a: got %b want 00", forward_a_e); end
        drive(0, 0, 0, 1, 2'b00, 0, 0, 1);          // writes x0
        drive(0, 0, 0, 1, 2'b00, 0, 0, 1);          // writes x0
        drive(0, 0, 2, 1, 2'b00, 0, 0, 1);          // reads x0, x0
        drive(0, 0, 0, 0, 2'b00, 0, 0, 1);
        checks += 2;
        if (forward_a_e !== 2'b00) begin errors++; $display("FAIL x0_a: got %b want 00", forward_a_e); end
        if (forward_b_e !== 2'b00) begin errors++; $display("FAIL x0_b: got %b want 00", forward_b_e); end
        $display("test_priority_x0 done");
    endtask

    task automatic test_load_use();
        flush_pipe();
        drive(1, 0, 3, 1, 2'b01, 0, 0, 1);          // lw x3
        drive(1, 3, 4, 1, 2'b00, 0, 0, 1);          // uses x3
        checks += 4;
        if (stall_f !== 1'b1) begin errors++; $display("FAIL lu_stall_f: got %b want 1", stall_f); end
        if (stall_d !== 1'b1) begin errors++; $display("FAIL lu_stall_d: got %b want 1", stall_d); end
        if (flush_e !== 1'b1) begin errors++; $display("FAIL lu_flush_e: got %b want 1", flush_e); end
        if (flush_d !== 1'b0) begin errors++; $display("FAIL lu_flush_d: got %b want 0", flush_d); end
        drive(1, 3, 4, 1, 2'b00, 0, 0, 1);          // re-presented after stall
        checks += 4;
        if (stall_f !== 1'b0) begin errors++; $display("FAIL lu2_stall_f: got %b want 0", stall_f); end
        if (flush_e !== 1'b0) begin errors++; $display("FAIL lu2_flush_e: got %b want 0", flush_e); end
        if (freeze !== 1'b0) begin errors++; $display("FAIL lu2_freeze: got %b want 0", freeze); end
        if (forward_b_e !== 2'b00) begin errors++; $display("FAIL lu2_fb_bubble: got %b want 00", forward_b_e); end
        drive(0, 0, 0, 0, 2'b00, 0, 0, 1);
        checks += 2;
        if (forward_b_e !== 2'b01) begin errors++; $display("FAIL lu_fb_wb: got %b want 01", forward_b_e); end
        if (forward_a_e !== 2'b00) begin errors++; $display("FAIL lu_fa: got %b want 00", forward_a_e); end
        $display("test_load_use done");
    endtask

    task automatic test_branch();
        flush_pipe();
        drive(1, 0, 3, 1, 2'b01, 0, 0, 1);          // lw x3
        drive(3, 0, 4, 1, 2'b00, 0, 1, 1);          // uses x3, branch taken
        checks += 4;
        if (flush_d !== 1'b1) begin errors++; $display("FAIL br_flush_d: got %b want 1", flush_d); end
        if (flush_e !== 1'b1) begin errors++; $display("FAIL br_flush_e: got %b want 1", flush_e); end
        if (stall_f !== 1'b0) begin errors++; $display("FAIL br_stall_f: got %b want 0", stall_f); end
        if (stall_d !== 1'b0) begin errors++; $display("FAIL br_stall_d: got %b want 0", stall_d); end
        drive(0, 0, 0, 0, 2'b00, 0, 0, 1);
        checks += 2;
        if (flush_d !== 1'b0) begin errors++; $display("FAIL br2_flush_d: got %b want 0", flush_d); end
        if (flush_e !== 1'b0) begin errors++; $display("FAIL br2_flush_e: got %b want 0", flush_e); end
        $display("test_branch done");
    endtask

    task automatic test_mem_wait();
        flush_pipe();
        drive(0, 0, 10, 1, 2'b00, 0, 0, 1);         // add x10
        drive(0, 0, 9, 1, 2'b01, 0, 0, 1);          // lw x9
        drive(0, 10, 11, 1, 2'b00, 0, 0, 1);        // reads x10, writes x11
        for (int i = 0; i < 3; i++) begin
            drive(11, 0, 12, 1, 2'b00, 0, (i == 1), 0);
            checks += 5;
            if (freeze !== 1'b1) begin errors++; $display("FAIL mw_freeze[%0d]: got %b want 1", i, freeze); end
            if (forward_b_e !== 2'b01) begin errors++; $display("FAIL mw_fb[%0d]: got %b want 01", i, forward_b_e); end
            if (forward_a_e !== 2'b00) begin errors++; $display("FAIL mw_fa[%0d]: got %b want 00", i, forward_a_e); end
            if (flush_d !== 1'b0) begin errors++; $display("FAIL mw_flush_d[%0d]: got %b want 0", i, flush_d); end
            if (flush_e !== 1'b0) begin errors++; $display("FAIL mw_flush_e[%0d]: got %b want 0", i, flush_e); end
        end
        drive(11, 0, 12, 1, 2'b00, 0, 0, 1);
        checks += 2;
        if (freeze !== 1'b0) begin errors++; $display("FAIL mw_release: got %b want 0", freeze); end
        if (forward_b_e !== 2'b01) begin errors++; $display("FAIL mw_fb_release: got %b want 01", forward_b_e); end
        drive(0, 0, 0, 0, 2'b00, 0, 0, 1);
        checks += 3;
        if (forward_a_e !== 2'b10) begin errors++; $display("FAIL mw_advance_fa: got %b want 10", forward_a_e); end
        if (freeze !== 1'b0) begin errors++; $display("FAIL mw_after_freeze: got %b want 0", freeze); end
        if (mem_timeout !== 1'b0) begin errors++; $display("FAIL mw_timeout: got %b want 0", mem_timeout); end
        $display("test_mem_wait done");
    endtask

    task automatic test_timeout();
        flush_pipe();
        drive(0, 0, 12, 1, 2'b01, 0, 0, 1);         // lw x12
        drive(0, 0, 0, 0, 2'b00, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 2'b00, 0, 0, 0);
            checks += 2;
            if (freeze !== 1'b1) begin errors++; $display("FAIL to_freeze[%0d]: got %b want 1", i, freeze); end
            if (mem_timeout !== (i >= MAX_WAIT)) begin
                errors++; $display("FAIL to_flag[%0d]: got %b want %b", i, mem_timeout, (i >= MAX_WAIT));
            end
        end
        drive(0, 0, 0, 0, 2'b00, 0, 0, 1);
        checks += 2;
        if (freeze !== 1'b0) begin errors++; $display("FAIL to_release: got %b want 0", freeze); end
        if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", mem_timeout); end
        flush_pipe();
        checks++;
        if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky2: got %b want 1", mem_timeout); end
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid_wait();
        flush_pipe();
        drive(0, 0, 13, 1, 2'b01, 0, 0, 1);         // lw x13
        drive(0, 0, 0, 0, 2'b00, 0, 0, 1);
        drive(0, 0, 0, 0, 2'b00, 0, 1, 0);
        checks += 2;
        if (freeze !== 1'b1) begin errors++; $display("FAIL rmw_freeze: got %b want 1", freeze); end
        if (flush_d !== 1'b0) begin errors++; $display("FAIL rmw_flush_d: got %b want 0", flush_d); end
        drive(0, 0, 0, 0, 2'b00, 0, 1, 0);
        rst = 1'b1;
        #1;
        checks += 6;
        if (freeze !== 1'b0) begin errors++; $display("FAIL rmw_rst_freeze: got %b want 0", freeze); end
        if (flush_d !== 1'b0) begin errors++; $display("FAIL rmw_rst_flush_d: got %b want 0", flush_d); end
        if (flush_e !== 1'b0) begin errors++; $display("FAIL rmw_rst_flush_e: got %b want 0", flush_e); end
        if (stall_f !== 1'b0) begin errors++; $display("FAIL rmw_rst_stall: got %b want 0", stall_f); end
        if (mem_timeout !== 1'b0) begin errors++; $display("FAIL rmw_rst_timeout: got %b want 0", mem_timeout); end
        if ({forward_a_e, forward_b_e} !== 4'b0000) begin
            errors++; $display("FAIL rmw_rst_fwd: got %b want 0000", {forward_a_e, forward_b_e});
        end
        @(negedge clk);
        rst = 1'b0; pc_src_e = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(5'(2 * i + 1), 5'(2 * i + 2), 5'(20 + i), 1, 2'b00, 0, 0, 1);
            else       drive(0, 0, 0, 0, 2'b00, 0, 0, 1);
            checks += 2;
            if (forward_a_e !== 2'b00) begin errors++; $display("FAIL rmw_post_fa[%0d]: got %b want 00", i, forward_a_e); end
            if (forward_b_e !== 2'b00) begin errors++; $display("FAIL rmw_post_fb[%0d]: got %b want 00", i, forward_b_e); end
        end
        $display("test_reset_mid_wait done");
    endtask

    task automatic test_random();
        logic [4:0] s1, s2, d;
        logic       rw, mw, pcs, rdy;
        logic [1:0] rsrc;
        for (int n = 0; n < 200; n++) begin
            s1   = 5'($urandom_range(0, 7));
            s2   = 5'($urandom_range(0, 7));
            d    = 5'($urandom_range(0, 7));
            rw   = 1'($urandom_range(0, 1));
            rsrc = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
            mw   = ($urandom_range(0, 5) == 0);
            pcs  = ($urandom_range(0, 7) == 0);
            rdy  = ($urandom_range(0, 3) != 0);
            drive(s1, s2, d, rw, rsrc, mw, pcs, rdy);
            checks += 8;
            if (forward_a_e !== exp_fa) begin errors++; $display("FAIL rnd_fa[%0d]: got %b want %b", n, forward_a_e, exp_fa); end
            if (forward_b_e !== exp_fb) begin errors++; $display("FAIL rnd_fb[%0d]: got %b want %b", n, forward_b_e, exp_fb); end
            if (stall_f !== exp_stall) begin errors++; $display("FAIL rnd_stall_f[%0d]: got %b want %b", n, stall_f, exp_stall); end
            if (stall_d !== exp_stall) begin errors++; $display("FAIL rnd_stall_d[%0d]: got %b want %b", n, stall_d, exp_stall); end
            if (flush_d !== exp_flush_d) begin errors++; $display("FAIL rnd_flush_d[%0d]: got %b want %b", n, flush_d, exp_flush_d); end
            if (flush_e !== exp_flush_e) begin errors++; $display("FAIL rnd_flush_e[%0d]: got %b want %b", n, flush_e, exp_flush_e); end
            if (freeze !== exp_freeze) begin errors++; $display("FAIL rnd_freeze[%0d]: got %b want %b", n, freeze, exp_freeze); end
            if (mem_timeout !== mdl_timeout) begin errors++; $display("FAIL rnd_timeout[%0d]: got %b want %b", n, mem_timeout, mdl_timeout); end
            $display("rnd %0d: rs1=%0d rs2=%0d rd=%0d rw=%b src=%b mw=%b pc=%b rdy=%b -> fa=%b fb=%b st=%b fd=%b fe=%b fz=%b",
                     n, s1, s2, d, rw, rsrc, mw, pcs, rdy, forward_a_e, forward_b_e,
                     stall_f, flush_d, flush_e, freeze);
        end
        $display("test_random done");
    endtask

    initial begin
        rs1_d = '0; rs2_d = '0; rd_d = '0;
        reg_write_d = 1'b0; result_src_d = 2'b00; mem_write_d = 1'b0;
        pc_src_e = 1'b1; mem_ready = 1'b0;
        rst = 1'b1;
        test_reset();
        test_forwarding();
        test_priority_x0();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
